// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: TX FIFO / holding register, baud tick generator, shifter handshake FSM, THRE/TEMT status.
// Optional feature macro UART_TX_OVERRUN_FLAG_EN adds the sticky tx_ovr_out dropped-write flag.
module uart_tx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        fifo_en_in,
    input  logic                        fifo_clr_in,
    input  logic [DIV_WIDTH-1:0]        divisor_in,
    input  logic                        wr_en_in,
    input  logic [7:0]                  wr_data_in,
    input  logic                        shift_finish_in,
    output logic                        bclk_tick_out,
    output logic                        shift_enable_out,
    output logic [7:0]                  shift_data_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
    output logic                        fifo_full_out,
    output logic                        thre_out,
    output logic                        temt_out,
`ifdef UART_TX_OVERRUN_FLAG_EN
    output logic                        tx_ovr_out,
`endif
    output logic                        thre_int_out
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div_prev;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_tick;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [LW-1:0]        w_level_nxt;
    logic [LW-1:0]        w_eff_depth;
    logic                 r_fifo_en;
    logic                 r_fin_d;
    logic                 r_fin_seen;
    logic [7:0]           r_shift_data;
    logic                 r_thre;
    logic                 r_thre_int;
    logic                 w_div_zero;
    logic                 w_div_chg;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_fin_rise;

    assign w_div_zero  = (divisor_in == '0);
    assign w_div_chg   = (divisor_in != r_div_prev);
    assign w_flush     = fifo_clr_in || (fifo_en_in != r_fifo_en);
    assign w_eff_depth = r_fifo_en ? LW'(FIFO_DEPTH) : LW'(1);
    assign w_full      = (r_level == w_eff_depth);
    assign w_pop       = (r_state == S_LOAD);
    assign w_push      = wr_en_in && !w_flush && (!w_full || w_pop);
    assign w_fin_rise  = shift_finish_in && !r_fin_d;

    // Baud divider: a divisor change only reloads, so the first tick lands a full period later
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div_prev <= '0;
            r_cnt      <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_div_prev <= divisor_in;
            r_tick     <= 1'b0;
            if (w_div_zero) begin
                r_cnt <= '0;
            end else if (w_div_chg) begin
                r_cnt <= divisor_in - DIV_WIDTH'(1);
            end else if (r_cnt == '0) begin
                r_cnt  <= divisor_in - DIV_WIDTH'(1);
                r_tick <= 1'b1;
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_in;
        end
    end

    // FIFO pointers, occupancy and THRE status; a pop in the flush cycle still reaches the shifter
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_fifo_en    <= 1'b0;
            r_shift_data <= '0;
            r_thre       <= 1'b1;
            r_thre_int   <= 1'b0;
        end else begin
            r_fifo_en  <= fifo_en_in;
            r_level    <= w_level_nxt;
            r_thre     <= (w_level_nxt == '0);
            r_thre_int <= (w_level_nxt == '0) && !r_thre;
            if (w_pop) begin
                r_shift_data <= r_mem[r_rd_ptr];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // Finish edge is remembered so a rise seen while the divisor is zero is not lost
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fin_d    <= 1'b0;
            r_fin_seen <= 1'b0;
        end else begin
            r_fin_d    <= shift_finish_in;
            r_fin_seen <= (r_state == S_SEND) && (r_fin_seen || w_fin_rise);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_flush && !w_div_zero && (r_level != '0 || w_push)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_SEND;
            S_SEND: begin
                if ((w_fin_rise || r_fin_seen) && !w_div_zero) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        shift_enable_out = (r_state == S_SEND);
        temt_out         = r_thre && (r_state == S_IDLE);
    end

`ifdef UART_TX_OVERRUN_FLAG_EN
    logic r_ovr;
    logic w_drop;

    assign w_drop = wr_en_in && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ovr <= 1'b0;
        end else if (fifo_clr_in) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end
    end

    assign tx_ovr_out = r_ovr;
`endif

    assign bclk_tick_out  = r_tick;
    assign shift_data_out = r_shift_data;
    assign fifo_level_out = r_level;
    assign fifo_full_out  = w_full;
    assign thre_out       = r_thre;
    assign thre_int_out   = r_thre_int;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: queue-level reference model checked every cycle, directed scenarios, then random traffic.
module tb_uart_tx_ctrl;

    localparam int DEPTH = 16;
    localparam int FT    = 3;   // baud ticks per frame in the shifter stand-in

    typedef enum int {P_WAIT, P_FETCH, P_AIR, P_SETTLE} phase_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_en;
    logic        fifo_clr;
    logic [15:0] divisor;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        fin;
    logic        bclk_tick_out;
    logic        shift_enable_out;
    logic [7:0]  shift_data_out;
    logic [4:0]  fifo_level_out;
    logic        fifo_full_out;
    logic        thre_out;
    logic        temt_out;
    logic        thre_int_out;
`ifdef UART_TX_OVERRUN_FLAG_EN
    logic        tx_ovr_out;
    logic        m_ovr;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic       stall;
    logic [7:0] tx_log[$];

    // Model state: what the spec says is queued, on the wire, and flagged
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    phase_t     m_ph;
    logic       m_fen, m_fin_prev, m_fin_seen, m_tick, m_thre, m_thre_int;
    logic [15:0] m_div;
    int         m_edge, m_ec;

    uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .fifo_en_in      (fifo_en),
        .fifo_clr_in     (fifo_clr),
        .divisor_in      (divisor),
        .wr_en_in        (wr_en),
        .wr_data_in      (wr_data),
        .shift_finish_in (fin),
        .bclk_tick_out   (bclk_tick_out),
        .shift_enable_out(shift_enable_out),
        .shift_data_out  (shift_data_out),
        .fifo_level_out  (fifo_level_out),
        .fifo_full_out   (fifo_full_out),
        .thre_out        (thre_out),
        .temt_out        (temt_out),
`ifdef UART_TX_OVERRUN_FLAG_EN
        .tx_ovr_out      (tx_ovr_out),
`endif
        .thre_int_out    (thre_int_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_cur = 8'h00; m_ph = P_WAIT; m_fen = 1'b0; m_fin_prev = 1'b0; m_fin_seen = 1'b0;
        m_tick = 1'b0; m_thre = 1'b1; m_thre_int = 1'b0; m_div = 16'h0; m_edge = 0; m_ec = 0;
`ifdef UART_TX_OVERRUN_FLAG_EN
        m_ovr = 1'b0;
`endif
    endfunction

    function automatic void model_step();
        bit     flush, full, accept, rise;
        phase_t nph;
        m_edge++;
        flush  = fifo_clr || (fifo_en != m_fen);
        full   = (m_q.size() == (m_fen ? DEPTH : 1));
        accept = wr_en && !flush && (!full || m_ph == P_FETCH);
        rise   = fin && !m_fin_prev;
`ifdef UART_TX_OVERRUN_FLAG_EN
        if (fifo_clr) m_ovr = 1'b0;
        else if (wr_en && !flush && full && m_ph != P_FETCH) m_ovr = 1'b1;
`endif
        nph = m_ph;
        case (m_ph)
            P_WAIT:   if (!flush && divisor != 0 && (m_q.size() > 0 || accept)) nph = P_FETCH;
            P_FETCH:  begin m_cur = m_q.pop_front(); nph = P_AIR; end
            P_AIR:    if ((rise || m_fin_seen) && divisor != 0) nph = P_SETTLE;
            P_SETTLE: if (m_tick) nph = P_WAIT;
            default:  nph = P_WAIT;
        endcase
        m_fin_seen = (m_ph == P_AIR) && (m_fin_seen || rise);
        m_fin_prev = fin;
        if (flush) m_q.delete();
        if (accept) m_q.push_back(wr_data);
        m_fen = fifo_en;
        // Ticks fall every divisor edges counted from the edge that saw the last divisor change
        if (divisor != m_div) m_ec = m_edge;
        m_tick = (divisor != 0) && (m_edge > m_ec) && (((m_edge - m_ec) % int'(divisor)) == 0);
        m_div = divisor;
        m_thre_int = (m_q.size() == 0) && !m_thre;
        m_thre = (m_q.size() == 0);
        m_ph = nph;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("tick", bclk_tick_out, m_tick);
            chk("enable", shift_enable_out, m_ph == P_AIR);
            if (m_ph == P_AIR) chk("data", shift_data_out, m_cur);
            chk("level", fifo_level_out, m_q.size());
            chk("full", fifo_full_out, m_q.size() == (m_fen ? DEPTH : 1));
            chk("thre", thre_out, m_thre);
            chk("temt", temt_out, m_thre && m_ph == P_WAIT);
            chk("thre_int", thre_int_out, m_thre_int);
`ifdef UART_TX_OVERRUN_FLAG_EN
            chk("ovr", tx_ovr_out, m_ovr);
`endif
        end
    end

    // Shifter stand-in: finishes after FT ticks of enable, logs each frame started
    initial begin
        int   cnt;
        logic en_prev;
        cnt = 0; en_prev = 1'b0; fin = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fin = 1'b0; cnt = 0; en_prev = 1'b0;
            end else begin
                if (shift_enable_out && !en_prev) tx_log.push_back(shift_data_out);
                en_prev = shift_enable_out;
                if (!shift_enable_out) begin
                    fin = 1'b0; cnt = 0;
                end else if (bclk_tick_out && !stall) begin
                    cnt++;
                    if (cnt >= FT) fin = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int k = 0;
        while (temt_out !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, temt_out, 1'b1);
    endtask

    initial begin
        int last, nt, base, ints;
        bit ok;
        rst = 1'b1; fifo_en = 1'b0; fifo_clr = 1'b0; divisor = 16'd0;
        wr_en = 1'b0; wr_data = 8'h00; stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_thre", thre_out, 1'b1);
        chk("rst_temt", temt_out, 1'b1);
        chk("rst_tick", bclk_tick_out, 1'b0);
        chk("rst_en", shift_enable_out, 1'b0);
        chk("rst_data", shift_data_out, 8'h00);
        chk("rst_level", fifo_level_out, 5'd0);
        chk("rst_full", fifo_full_out, 1'b0);
        chk("rst_int", thre_int_out, 1'b0);
        divisor = 16'd4; rst = 1'b0;

        // Divisor 4: one tick every 4 clocks
        last = -1; nt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bclk_tick_out) begin
                if (last >= 0) chk("tick_period", i - last, 4);
                last = i; nt++;
            end
        end
        chk("tick_count", nt >= 3, 1'b1);

        fifo_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: enable two cycles after the write, one THRE interrupt after the pop
        put(8'hA5);
        chk("a5_load_en", shift_enable_out, 1'b0);
        chk("a5_thre_lo", thre_out, 1'b0);
        @(negedge clk);
        chk("a5_en", shift_enable_out, 1'b1);
        chk("a5_data", shift_data_out, 8'hA5);
        chk("a5_int", thre_int_out, 1'b1);
        wait_idle(200, "a5_temt");

        // 17 writes with the transmitter held: 16 kept, last dropped, sent in order
        divisor = 16'd0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) put(8'(i));
        chk("ovf_level", fifo_level_out, 5'd16);
        chk("ovf_full", fifo_full_out, 1'b1);
`ifdef UART_TX_OVERRUN_FLAG_EN
        chk("ovf_flag", tx_ovr_out, 1'b1);
`endif
        base = tx_log.size();
        divisor = 16'd4;
        wait_idle(2000, "ovf_drain");
        chk("ovf_count", tx_log.size() - base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < tx_log.size()) chk("ovf_seq", tx_log[base + i], i);

        // Holding-register mode: second write dropped while the first waits
        divisor = 16'd0; fifo_en = 1'b0;
        repeat (2) @(negedge clk);
        put(8'h11);
        put(8'h22);
        chk("thr_level", fifo_level_out, 5'd1);
        chk("thr_full", fifo_full_out, 1'b1);
        base = tx_log.size();
        divisor = 16'd4;
        wait_idle(300, "thr_drain");
        chk("thr_count", tx_log.size() - base, 1);
        if (tx_log.size() > base) chk("thr_byte", tx_log[base], 8'h11);

        // Clear mid-frame with three queued bytes
        fifo_en = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b1;
        base = tx_log.size();
        for (int i = 0; i < 4; i++) put(8'h31 + 8'(i));
        repeat (3) @(negedge clk);
        chk("clr_pre_level", fifo_level_out, 5'd3);
        chk("clr_pre_en", shift_enable_out, 1'b1);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        chk("clr_level", fifo_level_out, 5'd0);
        ints = thre_int_out ? 1 : 0;
        stall = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (thre_int_out) ints++;
        end
        chk("clr_temt", temt_out, 1'b1);
        chk("clr_int_count", ints, 1);
        chk("clr_sent", tx_log.size() - base, 1);
        if (tx_log.size() > base) chk("clr_byte", tx_log[base], 8'h31);

        // Divisor dropped to 0 mid-frame freezes it; restoring lets it finish
        put(8'h5A);
        repeat (3) @(negedge clk);
        divisor = 16'd0;
        @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bclk_tick_out || !shift_enable_out) ok = 1'b0;
        end
        chk("freeze_hold", ok, 1'b1);
        divisor = 16'd4;
        wait_idle(300, "freeze_done");
        if (tx_log.size() > 0) chk("freeze_byte", tx_log[tx_log.size() - 1], 8'h5A);

        // Random traffic checked by the per-cycle model
        for (int c = 0; c < 3000; c++) begin
            wr_en    = ($urandom_range(99) < 35);
            wr_data  = 8'($urandom);
            fifo_clr = ($urandom_range(199) == 0);
            stall    = ($urandom_range(3) == 0);
            if ($urandom_range(299) == 0) fifo_en = !fifo_en;
            if ($urandom_range(149) == 0) begin
                case ($urandom_range(4))
                    0: divisor = 16'd0;
                    1: divisor = 16'd1;
                    2: divisor = 16'd2;
                    3: divisor = 16'd3;
                    default: divisor = 16'd5;
                endcase
            end
            @(negedge clk);
        end
        wr_en = 1'b0; fifo_clr = 1'b0; stall = 1'b0; divisor = 16'd2;
        wait_idle(3000, "final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller that sequences the UART tx shift block. It buffers host-written characters in a TX FIFO, or a single holding register in non-FIFO mode, and generates the baud oversample tick from the divisor latch. It hands one character at a time to the shifter through an enable/finish handshake. It also produces the 16550-style THRE/TEMT status and the THRE interrupt pulse.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..64
DIV_WIDTH, 16, baud divisor width (DLH:DLL)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
fifo_en_in  input  1  1 = FIFO mode; 0 = single holding register (effective depth 1)
fifo_clr_in  input  1  one-cycle pulse; flushes TX FIFO
divisor_in  input  DIV_WIDTH  baud divisor; 0 = baud tick disabled
wr_en_in  input  1  host write strobe to THR
wr_data_in  input  8  THR write data
shift_finish_in  input  1  finish flag from shifter, synchronous to clk_in
bclk_tick_out  output  1  one-clk-wide oversample tick, drives shifter clock enable
shift_enable_out  output  1  enable to shifter; held high for one whole frame
shift_data_out  output  8  character presented to shifter; stable while enable is high
fifo_level_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_full_out  output  1  level == effective depth
thre_out  output  1  holding register/FIFO empty
temt_out  output  1  FIFO empty and FSM in IDLE
thre_int_out  output  1  one-cycle pulse on thre_out 0->1

Behaviour:
- Reset (rst_in high, asynchronous): FIFO empty, div counter 0, FSM IDLE. All outputs 0 except thre_out=1 and temt_out=1.
- Baud counter:
  - divisor_in==0: counter held at 0, no ticks.
  - Otherwise counts down from divisor_in-1. bclk_tick_out=1 for the cycle in which counter==0, then reloads. Divisor 1 gives a tick every clk.
  - Any change of divisor_in reloads the counter on the next clk; no tick is produced in that cycle.
- FIFO write:
  - wr_en_in accepted if !fifo_full_out, or if a pop happens in the same cycle.
  - Otherwise the write is dropped.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- fifo_clr_in, or any toggle of fifo_en_in: level and pointers go to 0 next cycle. A character already in the shifter is not aborted. A write in the same cycle as clear is dropped.
- FSM states:
  - IDLE: if level>0 and divisor!=0 -> LOAD.
  - LOAD (1 clk): pop head into shift_data_out -> SEND.
  - SEND: shift_enable_out=1. On shift_finish_in rising edge (registered edge detect) -> GAP.
  - GAP: shift_enable_out=0 for exactly one bclk tick, letting the shifter return to reset -> IDLE.
- Latency: write into empty FIFO at cycle N gives shift_enable_out high at N+2 (N+1 IDLE->LOAD, N+2 SEND).
- divisor_in set to 0 during SEND/GAP: the FSM holds its state (frame frozen) until the divisor is non-zero again.
- Status flags:
  - thre_out = (level==0), registered.
  - temt_out = thre_out && state==IDLE.
  - thre_int_out pulses exactly once per 0->1 transition of thre_out, including the transition caused by a flush. No pulse out of reset.
- Back-to-back: a character written during SEND starts at GAP->IDLE->LOAD with no extra idle ticks beyond GAP.

Optional Feature:
UART_TX_OVERRUN_FLAG_EN:
- Defined: adds output tx_ovr_out (1 bit). Sticky flag set when a write is dropped because the FIFO is full. Cleared by fifo_clr_in or rst_in. Reset value 0.
- Not defined: port absent; dropped writes are silent.

Test Plan:
- Reset, divisor=4 -> bclk_tick_out pulses every 4th clk; thre_out=1, temt_out=1, others 0.
- fifo_en=1, write 0xA5 -> shift_enable_out high 2 clk later with shift_data_out=0xA5; thre_out 1->0->1 with one thre_int_out pulse after the pop; temt_out=1 after GAP.
- Write 17 bytes 0x00..0x10 with the shifter stalled -> level saturates at 16; 17th byte dropped (tx_ovr_out=1 if enabled); sequence transmitted 0x00..0x0F in order.
- fifo_en=0, write 0x11 then 0x22 while the first is still in holding -> 0x22 dropped (full at level 1); only 0x11 sent.
- Mid-frame fifo_clr_in with 3 queued bytes -> current frame completes; level=0 next clk; no further shift_enable_out; one thre_int_out pulse.
- divisor changed from 4 to 0 during SEND -> ticks stop and FSM holds; restore divisor to 4 -> frame completes normally.
